// File: rtl/fifo_pkg.sv
// Shared constants and parameter-legality helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int DATA_W_DEF = 32'sd8;
  localparam int DEPTH_DEF  = 32'sd16;

  function automatic logic is_pow2(input int n);
    return (n > 32'sd0) && ((n & (n - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register-array storage: one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // storage write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with registered status flags, error pulses
// and selectable registered-read or first-word-fall-through output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 32'sd2,
  parameter int AE_LEVEL = 32'sd2,
  parameter int FWFT     = 32'sd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE_L   = PW'(32'd1);
  localparam logic [PW-1:0] ZERO_L  = PW'(32'd0);
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);

  generate
    if (!is_pow2(DEPTH) || (DEPTH < 32'sd4) || (AE_LEVEL >= AF_LEVEL)) begin : g_bad_params
      $error("sync_fifo_param: DEPTH must be a power of 2 (>=4) and AE_LEVEL < AF_LEVEL");
    end
  endgenerate

  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_count;
  logic              r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [DATA_W-1:0] r_dout;

  logic              w_wr_acc, w_rd_acc, w_ovf, w_udf;
  logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_rdata, w_dout_nxt;

  // access acceptance, pointer and occupancy next-state
  always_comb begin
    w_rd_acc     = rd_en & ~r_empty;
    w_wr_acc     = wr_en & (~r_full | w_rd_acc);
    w_ovf        = wr_en & ~w_wr_acc;
    w_udf        = rd_en & ~w_rd_acc;
    w_wr_ptr_nxt = w_wr_acc ? (r_wr_ptr + ONE_L) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_acc ? (r_rd_ptr + ONE_L) : r_rd_ptr;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + ONE_L;
      2'b01:   w_count_nxt = r_count - ONE_L;
      default: w_count_nxt = r_count;
    endcase
  end

  // FWFT reads the entry that will be head after this edge
  assign w_raddr = (FWFT != 32'sd0) ? w_rd_ptr_nxt[AW-1:0] : r_rd_ptr[AW-1:0];

  // output data next-state; FWFT bypasses a write landing in the new head slot
  always_comb begin
    w_dout_nxt = r_dout;
    if (FWFT != 32'sd0) begin
      if (w_count_nxt == ZERO_L) begin
        w_dout_nxt = r_dout;
      end else if (w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt)) begin
        w_dout_nxt = data_in;
      end else begin
        w_dout_nxt = w_rdata;
      end
    end else begin
      if (w_rd_acc) begin
        w_dout_nxt = w_rdata;
      end else begin
        w_dout_nxt = r_dout;
      end
    end
  end

  // state and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= ZERO_L;
      r_rd_ptr <= ZERO_L;
      r_count  <= ZERO_L;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_L);
      r_empty  <= (w_count_nxt == ZERO_L);
      r_af     <= (w_count_nxt >= AF_L);
      r_ae     <= (w_count_nxt <= AE_L);
      r_ovf    <= w_ovf;
      r_udf    <= w_udf;
      r_dout   <= w_dout_nxt;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (data_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign data_out     = r_dout;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one registered-read FIFO and one FWFT FIFO, both 8x16.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] cnt0, cnt1;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din0), .wr_en(wr0), .rd_en(rd0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din1), .wr_en(wr1), .rd_en(rd1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_total++; if ({full0, af0, ovf0, udf0} !== 4'b0000) $display("FAIL reset_lo_flags: got %b expected 0000", {full0, af0, ovf0, udf0}); else n_pass++;
    n_total++; if ({empty0, ae0} !== 2'b11) $display("FAIL reset_hi_flags: got %b expected 11", {empty0, ae0}); else n_pass++;
    n_total++; if (cnt0 !== 5'd0) $display("FAIL reset_count: got %0d expected 0", cnt0); else n_pass++;
    n_total++; if (dout0 !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout0); else n_pass++;
    n_total++; if ({empty1, cnt1} !== {1'b1, 5'd0}) $display("FAIL reset_fwft: got %b/%0d expected 1/0", empty1, cnt1); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr0 = 1'b1; din0 = 8'(i);
      tick();
      n_total++; if (cnt0 !== 5'(i + 1)) $display("FAIL fill_count: got %0d expected %0d", cnt0, i + 1); else n_pass++;
      n_total++; if (af0 !== ((i + 1) >= 14)) $display("FAIL fill_af: got %b expected %b at count %0d", af0, ((i + 1) >= 14), i + 1); else n_pass++;
    end
    n_total++; if ({full0, empty0} !== 2'b10) $display("FAIL fill_full: got %b expected 10", {full0, empty0}); else n_pass++;
    din0 = 8'h77;
    tick();
    n_total++; if (ovf0 !== 1'b1) $display("FAIL overflow_pulse: got %b expected 1", ovf0); else n_pass++;
    n_total++; if (cnt0 !== 5'd16) $display("FAIL overflow_count: got %0d expected 16", cnt0); else n_pass++;
    wr0 = 1'b0;
    tick();
    n_total++; if (ovf0 !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", ovf0); else n_pass++;
  endtask

  task automatic test_drain();
    rd0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_total++; if (dout0 !== 8'(i)) $display("FAIL drain_data: got %h expected %h", dout0, 8'(i)); else n_pass++;
      n_total++; if (ae0 !== ((15 - i) <= 2)) $display("FAIL drain_ae: got %b expected %b", ae0, ((15 - i) <= 2)); else n_pass++;
    end
    tick();
    n_total++; if (udf0 !== 1'b1) $display("FAIL underflow_pulse: got %b expected 1", udf0); else n_pass++;
    n_total++; if (dout0 !== 8'h0F) $display("FAIL underflow_hold: got %h expected 0f", dout0); else n_pass++;
    n_total++; if (empty0 !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty0); else n_pass++;
    rd0 = 1'b0;
    tick();
    n_total++; if (udf0 !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", udf0); else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_v;
    for (int i = 0; i < 16; i++) begin
      wr0 = 1'b1; din0 = 8'(i);
      tick();
    end
    rd0 = 1'b1; din0 = 8'hAA;
    tick();
    n_total++; if (cnt0 !== 5'd16) $display("FAIL full_rw_count: got %0d expected 16", cnt0); else n_pass++;
    n_total++; if (ovf0 !== 1'b0) $display("FAIL full_rw_ovf: got %b expected 0", ovf0); else n_pass++;
    n_total++; if (dout0 !== 8'h00) $display("FAIL full_rw_data: got %h expected 00", dout0); else n_pass++;
    wr0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_v = (i < 15) ? 8'(i + 1) : 8'hAA;
      n_total++; if (dout0 !== exp_v) $display("FAIL full_rw_order: got %h expected %h", dout0, exp_v); else n_pass++;
    end
    rd0 = 1'b0;
  endtask

  task automatic test_empty_rw();
    wr0 = 1'b1; rd0 = 1'b1; din0 = 8'h33;
    tick();
    n_total++; if (udf0 !== 1'b1) $display("FAIL empty_rw_udf: got %b expected 1", udf0); else n_pass++;
    n_total++; if (cnt0 !== 5'd1) $display("FAIL empty_rw_count: got %0d expected 1", cnt0); else n_pass++;
    n_total++; if (dout0 !== 8'hAA) $display("FAIL empty_rw_hold: got %h expected aa", dout0); else n_pass++;
    wr0 = 1'b0;
    tick();
    n_total++; if (dout0 !== 8'h33) $display("FAIL empty_rw_data: got %h expected 33", dout0); else n_pass++;
    n_total++; if (empty0 !== 1'b1) $display("FAIL empty_rw_empty: got %b expected 1", empty0); else n_pass++;
    rd0 = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      wr0 = 1'b1; din0 = 8'(8'h40 + i);
      tick();
    end
    rd0 = 1'b1;
    for (int j = 0; j < 17; j++) begin
      din0 = 8'(8'h43 + j);
      tick();
      n_total++; if (dout0 !== 8'(8'h40 + j)) $display("FAIL wrap_data: got %h expected %h", dout0, 8'(8'h40 + j)); else n_pass++;
      n_total++; if (cnt0 !== 5'd3) $display("FAIL wrap_count: got %0d expected 3", cnt0); else n_pass++;
    end
    wr0 = 1'b0;
    for (int j = 17; j < 20; j++) begin
      tick();
      n_total++; if (dout0 !== 8'(8'h40 + j)) $display("FAIL wrap_tail: got %h expected %h", dout0, 8'(8'h40 + j)); else n_pass++;
    end
    rd0 = 1'b0;
    n_total++; if (empty0 !== 1'b1) $display("FAIL wrap_empty: got %b expected 1", empty0); else n_pass++;
  endtask

  task automatic test_fwft();
    wr1 = 1'b1; din1 = 8'h5A;
    tick();
    n_total++; if (dout1 !== 8'h5A) $display("FAIL fwft_first: got %h expected 5a", dout1); else n_pass++;
    n_total++; if (empty1 !== 1'b0) $display("FAIL fwft_empty: got %b expected 0", empty1); else n_pass++;
    din1 = 8'h6B;
    tick();
    n_total++; if (dout1 !== 8'h5A) $display("FAIL fwft_head_hold: got %h expected 5a", dout1); else n_pass++;
    wr1 = 1'b0; rd1 = 1'b1;
    tick();
    n_total++; if (dout1 !== 8'h6B) $display("FAIL fwft_advance: got %h expected 6b", dout1); else n_pass++;
    n_total++; if (cnt1 !== 5'd1) $display("FAIL fwft_count: got %0d expected 1", cnt1); else n_pass++;
    tick();
    n_total++; if ({empty1, cnt1} !== {1'b1, 5'd0}) $display("FAIL fwft_drain: got %b/%0d expected 1/0", empty1, cnt1); else n_pass++;
    rd1 = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      wr0 = 1'b1; din0 = 8'(8'h90 + i);
      tick();
    end
    wr0 = 1'b0;
    n_total++; if (cnt0 !== 5'd9) $display("FAIL pre_reset_count: got %0d expected 9", cnt0); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (cnt0 !== 5'd0) $display("FAIL async_count: got %0d expected 0", cnt0); else n_pass++;
    n_total++; if (empty0 !== 1'b1) $display("FAIL async_empty: got %b expected 1", empty0); else n_pass++;
    n_total++; if (dout0 !== 8'h00) $display("FAIL async_dout: got %h expected 00", dout0); else n_pass++;
    #1;
    rst_n = 1'b1;
    tick();
    n_total++; if ({empty0, cnt0} !== {1'b1, 5'd0}) $display("FAIL post_reset_discard: got %b/%0d expected 1/0", empty0, cnt0); else n_pass++;
    wr0 = 1'b1; din0 = 8'h11;
    tick();
    n_total++; if (cnt0 !== 5'd1) $display("FAIL post_reset_write: got %0d expected 1", cnt0); else n_pass++;
    wr0 = 1'b0; rd0 = 1'b1;
    tick();
    n_total++; if (dout0 !== 8'h11) $display("FAIL post_reset_read: got %h expected 11", dout0); else n_pass++;
    rd0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_fwft();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
